mem_arbiter: RTL and testbench

Arbitrates the single-port unified memory between instruction fetch (I side) and the MEM-stage load/store unit (D side) of the rv32 pipeline. One transaction is outstanding at a time. A watchdog aborts a stalled memory access with an error. The pipeline controller stalls each stage while that stage's request is pending, using `i_gnt`/`d_gnt` and `i_rvalid`/`d_rvalid`.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_wdog.sv | 39 +++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for mem_arbiter: FSM encodings, owner ids and watchdog sizing.
package mem_arb_pkg;

  localparam int unsigned MASK_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Counter width able to hold 0..timeout.
  function automatic int unsigned wdog_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for mem_arbiter: clearable, enabled counter flagging TIMEOUT-1 cycles in WAIT.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = wdog_w(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Saturate at the expiry value so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D), one access in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D always beats I.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              i_err_q, i_err_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic              wdog_clr, wdog_en, wdog_expired;
  logic              prefer_d;

`ifdef MEM_ARB_RR_EN
  logic last_own_q, last_own_d;
  assign prefer_d = (last_own_q == OWN_I);
`else
  assign prefer_d = 1'b1;
`endif

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wdog_clr),
    .en_i      (wdog_en),
    .expired_o (wdog_expired)
  );

  // Next-state, grant and response logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    i_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    i_err_d     = i_err_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    wdog_clr    = 1'b0;
    wdog_en     = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_own_d  = last_own_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rst && (i_req || d_req)) begin
          d_gnt       = d_req && (!i_req || prefer_d);
          i_gnt       = !d_gnt;
          owner_d     = d_gnt ? OWN_D : OWN_I;
          mem_req_d   = 1'b1;
          mem_we_d    = d_gnt && d_we;
          mem_addr_d  = d_gnt ? d_addr : i_addr;
          mem_wdata_d = d_gnt ? d_wdata : '0;
          mem_wmask_d = d_gnt ? d_wmask : {MASK_W{1'b1}};
          state_d     = ST_REQ;
`ifdef MEM_ARB_RR_EN
          last_own_d  = owner_d;
`endif
        end
      end
      ST_REQ: begin
        wdog_clr = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_en = 1'b1;
        if (mem_rvalid || wdog_expired) begin
          state_d = ST_RESP;
          if (owner_q == OWN_I) begin
            i_rvalid_d = 1'b1;
            i_err_d    = !mem_rvalid;
            i_rdata_d  = mem_rvalid ? mem_rdata : '0;
          end else begin
            d_rvalid_d = 1'b1;
            d_err_d    = !mem_rvalid;
            // A completed store leaves the previous load data in place.
            if (!mem_rvalid) begin
              d_rdata_d = '0;
            end else if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      i_err_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_own_q  <= OWN_D;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      i_rvalid_q  <= i_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      i_err_q     <= i_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
`ifdef MEM_ARB_RR_EN
      last_own_q  <= last_own_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): vector table of single transactions plus corner sequences.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [3:0]    d_wmask;
  logic          mem_req, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        side_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          lat;       // cycles from mem_req to mem_rvalid, 0 = never answers
    logic [31:0] rdata;
    int          exp_cyc;   // x_rvalid cycle relative to grant cycle
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_mask;
    logic        late;      // inject a stray mem_rvalid in IDLE afterwards
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] exp_i_rdata = 32'h0;
  logic [31:0] exp_d_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   got;
    logic other_seen;
    next_cycle();
    if (v.side_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    @(negedge clk);
    chk("gnt_own", 32'(v.side_d ? d_gnt : i_gnt), 32'd1);
    chk("gnt_other", 32'(v.side_d ? i_gnt : d_gnt), 32'd0);
    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("mem_req", 32'(mem_req), 32'd1);
    chk("mem_we", 32'(mem_we), 32'(v.side_d & v.we));
    chk("mem_addr", mem_addr, v.addr);
    chk("mem_wmask", 32'(mem_wmask), 32'(v.exp_mask));
    if (v.side_d && v.we) chk("mem_wdata", mem_wdata, v.wdata);
    got = 0;
    other_seen = 1'b0;
    for (int c = 2; c <= 12 && got == 0; c++) begin
      next_cycle();
      mem_rvalid = (v.lat != 0) && (c == v.lat + 1);
      mem_rdata  = mem_rvalid ? v.rdata : 32'h0;
      @(negedge clk);
      if (v.side_d ? i_rvalid : d_rvalid) other_seen = 1'b1;
      if (v.side_d ? d_rvalid : i_rvalid) got = c;
    end
    mem_rvalid = 1'b0;
    chk("rvalid_cycle", 32'(got), 32'(v.exp_cyc));
    chk("rdata", v.side_d ? d_rdata : i_rdata, v.exp_data);
    chk("err", 32'(v.side_d ? d_err : i_err), 32'(v.exp_err));
    chk("other_rvalid", 32'(other_seen), 32'd0);
    chk("other_rdata_hold", v.side_d ? i_rdata : d_rdata, v.side_d ? exp_i_rdata : exp_d_rdata);
    if (v.side_d) exp_d_rdata = v.exp_data;
    else          exp_i_rdata = v.exp_data;
    next_cycle();
    @(negedge clk);
    chk("rvalid_pulse", 32'(v.side_d ? d_rvalid : i_rvalid), 32'd0);
    if (v.late) begin
      next_cycle();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
      next_cycle();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("late_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("late_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("late_mem_req", 32'(mem_req), 32'd0);
      chk("late_d_rdata", d_rdata, exp_d_rdata);
    end
  endtask

  logic exp_dgnt [3];

  initial begin
    //           side we    addr          wdata         mask    lat rdata         cyc data          err   mask   late
    vecs[0] = '{1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'b0011, 1, 32'h0,         3, 32'h0,         1'b0, 4'b0011, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'b0000, 3, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF, 1'b0, 4'hF,    1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,         4'hF,    2, 32'h1234_5678, 4, 32'h1234_5678, 1'b0, 4'hF,    1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_3008, 32'h55AA_55AA, 4'b1100, 1, 32'h0,         3, 32'h1234_5678, 1'b0, 4'b1100, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         4'hF,    0, 32'h0,         6, 32'h0,         1'b1, 4'hF,    1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'b0000, 1, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1'b0, 4'hF,    1'b0};

`ifdef MEM_ARB_RR_EN
    exp_dgnt[0] = 1'b1; exp_dgnt[1] = 1'b0; exp_dgnt[2] = 1'b1;
`else
    exp_dgnt[0] = 1'b1; exp_dgnt[1] = 1'b1; exp_dgnt[2] = 1'b1;
`endif

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_rvalid", 32'({i_rvalid, d_rvalid, i_err, d_err}), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Both sides requesting continuously for three transactions.
    next_cycle();
    i_req = 1'b1; i_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0800; d_wmask = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("both_d_gnt", 32'(d_gnt), 32'(exp_dgnt[k]));
      chk("both_i_gnt", 32'(i_gnt), 32'(!exp_dgnt[k]));
      next_cycle();
      @(negedge clk);
      chk("both_mem_addr", mem_addr, exp_dgnt[k] ? 32'h0000_0800 : 32'h0000_0400);
      next_cycle();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0000_1000 + 32'(k);
      next_cycle();
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("both_rvalid", 32'(exp_dgnt[k] ? d_rvalid : i_rvalid), 32'd1);
      chk("both_rdata", exp_dgnt[k] ? d_rdata : i_rdata, 32'h0000_1000 + 32'(k));
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;

    // Reset in WAIT with a response pending.
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000;
    next_cycle();
    d_req = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    next_cycle();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0600;
    @(negedge clk);
    chk("post_rst_i_gnt", 32'(i_gnt), 32'd1);
    chk("post_rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("post_rst_mem", 32'({mem_req, mem_we, mem_wmask}), 32'd0);
    chk("post_rst_mem_addr", mem_addr, 32'h0);
    chk("post_rst_rvalid", 32'({i_rvalid, d_rvalid, i_err, d_err}), 32'd0);
    chk("post_rst_rdata", i_rdata | d_rdata, 32'h0);
    next_cycle();
    i_req = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_req", 32'(mem_req), 32'd1);
    chk("post_rst_mem_addr2", mem_addr, 32'h0000_0600);
    chk("post_rst_no_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0060_0600;
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("post_rst_i_rdata", i_rdata, 32'h0060_0600);
    chk("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle();

    // I request withdrawn during RESP is never issued.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_7000; d_wdata = 32'h1; d_wmask = 4'hF;
    @(negedge clk);
    chk("wd_d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0900;
    @(negedge clk);
    chk("wd_i_gnt_req", 32'(i_gnt), 32'd0);
    next_cycle();
    mem_rvalid = 1'b1;
    @(negedge clk);
    chk("wd_i_gnt_wait", 32'(i_gnt), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    chk("wd_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("wd_i_gnt_resp", 32'(i_gnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("wd_idle_i_gnt", 32'(i_gnt), 32'd0);
      chk("wd_idle_mem_req", 32'(mem_req), 32'd0);
      chk("wd_idle_i_rvalid", 32'(i_rvalid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
